stall_ctrl: RTL
===============

STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: hdu_stall  in  1  load-use stall request from the hazard detection unit.
REQ-004 SHALL have ports: imem_stall  in  1  instruction memory not ready.
REQ-005 SHALL have ports: dmem_stall  in  1  data memory not ready.
REQ-006 SHALL have ports: branch_flush  in  1  taken branch/jump resolved; wrong-path instruction in IF/ID.
REQ-007 SHALL have ports: halt  in  1  HALT decoded in ID.
REQ-008 SHALL have outputs (1 bit each): pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_we, halted.
REQ-009 SHALL have outputs: load_use_cnt, dmem_wait_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-010 SHALL implement FSM states BOOT, RUN, DRAIN, HALTED.
REQ-011 SHALL drive outputs combinationally from the current state and the current-cycle inputs.
REQ-012 SHALL, in BOOT: pc_we=0, if_id_flush=1, id_ex_bubble=1, all other *_we=1; BOOT->RUN unconditionally after one cycle.
REQ-013 SHALL, in RUN, apply priority dmem_stall > branch_flush > hdu_stall > imem_stall > none.
REQ-014 SHALL, for dmem_stall: all *_we=0, flush=0, bubble=0 (full freeze).
REQ-015 SHALL, for branch_flush: pc_we=1, if_id_flush=1, id_ex_bubble=0, all other *_we=1.
REQ-016 SHALL, for hdu_stall: pc_we=0, if_id_we=0, id_ex_bubble=1, id_ex_we/ex_mem_we/mem_wb_we=1.
REQ-017 SHALL, for imem_stall: pc_we=0, if_id_flush=1, downstream *_we=1.
REQ-018 SHALL, with no request active: all *_we=1, flush=0, bubble=0.
REQ-019 SHALL take RUN->DRAIN when halt=1 and dmem_stall=0, with a 2-bit drain counter loaded with 3; halt under dmem_stall stays in RUN and freezes.
REQ-020 SHALL, in DRAIN: pc_we=0, if_id_flush=1, downstream *_we=1; branch_flush, hdu_stall and imem_stall ignored; dmem_stall freezes everything and holds the counter.
REQ-021 SHALL decrement the drain counter each non-frozen DRAIN cycle; DRAIN->HALTED on the cycle the counter decrements from 1 to 0.
REQ-022 SHALL, in HALTED: all *_we=0, flush=0, bubble=0, halted=1; HALTED is exited only by rst.
REQ-023 SHALL assert if_id_flush and if_id_we never both 0 while pc_we=1.
REQ-024 SHALL keep halted=0 in every state other than HALTED.

Reset
REQ-025 SHALL, on rst=1, asynchronously enter BOOT, clear the drain counter and all counters, and drive the BOOT output values.
REQ-026 SHALL, on rst asserted mid-DRAIN or mid-freeze, abandon the operation with no residual state.

Configuration
REQ-027 SHALL gate the performance counters with macro STALL_CTRL_PERF_EN.
REQ-028 SHALL, with STALL_CTRL_PERF_EN defined, increment each counter once per clock, saturating at 16'hFFFF:
- load_use_cnt: per RUN cycle where hdu_stall is honoured.
- dmem_wait_cnt: per frozen cycle in RUN or DRAIN.
- flush_cnt: per honoured branch_flush.
REQ-029 SHALL, with STALL_CTRL_PERF_EN undefined, instantiate no counter flops and tie all three counter outputs to 16'h0000, with ports retained.

Verification
REQ-030 SHALL cover: rst pulse, then idle inputs -> cycle 1 BOOT (pc_we=0, if_id_flush=1, id_ex_bubble=1), cycle 2 all *_we=1.
REQ-031 SHALL cover: hdu_stall=1 for one RUN cycle -> pc_we=0, if_id_we=0, id_ex_bubble=1 that cycle; load_use_cnt=1 (PERF).
REQ-032 SHALL cover: dmem_stall=1, branch_flush=1, hdu_stall=1 together for 3 cycles -> full freeze for 3 cycles, flush_cnt=0, dmem_wait_cnt=3; branch honoured on cycle 4 once dmem_stall drops.
REQ-033 SHALL cover: halt=1 in RUN with dmem_stall pulsed for 2 cycles during DRAIN -> HALTED reached after 5 cycles; halted=1 and all *_we=0 thereafter.
REQ-034 SHALL cover: rst asserted asynchronously mid-DRAIN (between clock edges) -> BOOT outputs immediately; counters read 0.
REQ-035 SHALL cover: hdu_stall held for 70000 cycles with PERF on -> load_use_cnt saturates at 16'hFFFF; with PERF off all counters read 0.

Source files
------------

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: BOOT/RUN/DRAIN/HALTED FSM with prioritised hazard handling.
// Optional performance counters are built only when STALL_CTRL_PERF_EN is defined.
module stall_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        hdu_stall,
  input  logic        imem_stall,
  input  logic        dmem_stall,
  input  logic        branch_flush,
  input  logic        halt,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_ex_we,
  output logic        id_ex_bubble,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        halted,
  output logic [15:0] load_use_cnt,
  output logic [15:0] dmem_wait_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] drain_cnt, drain_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      drain_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // A frozen DRAIN cycle holds the counter, so memory waits stretch the drain.
  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (halt && !dmem_stall) begin
          state_nxt = DRAIN;
          drain_nxt = 2'd3;
        end
      end
      DRAIN: begin
        if (!dmem_stall) begin
          drain_nxt = drain_cnt - 2'd1;
          if (drain_cnt == 2'd1) state_nxt = HALTED;
        end
      end
      HALTED: state_nxt = HALTED;
      default: begin
        state_nxt = BOOT;
        drain_nxt = 2'd0;
      end
    endcase
  end

  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_we    = 1'b0;
    mem_wb_we    = 1'b0;
    halted       = 1'b0;
    case (state)
      BOOT: begin
        if_id_we     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_we     = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_we    = 1'b1;
        mem_wb_we    = 1'b1;
      end
      RUN: begin
        if (dmem_stall) begin
          pc_we = 1'b0;
        end else if (branch_flush) begin
          pc_we       = 1'b1;
          if_id_we    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          mem_wb_we   = 1'b1;
        end else if (hdu_stall) begin
          id_ex_we     = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_we    = 1'b1;
          mem_wb_we    = 1'b1;
        end else if (imem_stall) begin
          if_id_we    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          mem_wb_we   = 1'b1;
        end else begin
          pc_we     = 1'b1;
          if_id_we  = 1'b1;
          id_ex_we  = 1'b1;
          ex_mem_we = 1'b1;
          mem_wb_we = 1'b1;
        end
      end
      DRAIN: begin
        if (!dmem_stall) begin
          if_id_we    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          mem_wb_we   = 1'b1;
        end
      end
      HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  // Fetch may only advance when IF/ID either captures or squashes.
  a_fetch_safe: assert property (@(posedge clk) disable iff (rst)
    pc_we |-> (if_id_we || if_id_flush));

`ifdef STALL_CTRL_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  logic hdu_honoured, dmem_frozen, flush_honoured;

  assign hdu_honoured   = (state == RUN) && !dmem_stall && !branch_flush && hdu_stall;
  assign dmem_frozen    = ((state == RUN) || (state == DRAIN)) && dmem_stall;
  assign flush_honoured = (state == RUN) && !dmem_stall && branch_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_use_cnt  <= 16'h0000;
      dmem_wait_cnt <= 16'h0000;
      flush_cnt     <= 16'h0000;
    end else begin
      load_use_cnt  <= sat_inc(load_use_cnt, hdu_honoured);
      dmem_wait_cnt <= sat_inc(dmem_wait_cnt, dmem_frozen);
      flush_cnt     <= sat_inc(flush_cnt, flush_honoured);
    end
  end
`else
  assign load_use_cnt  = 16'h0000;
  assign dmem_wait_cnt = 16'h0000;
  assign flush_cnt     = 16'h0000;
`endif

endmodule
